// File: rtl/nbload_cam_pkg.sv
// Shared types for the non-blocking load tracking CAM.
package nbload_cam_pkg;

  localparam int unsigned RD_W = 5;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    PEND   = 2'b01,
    ORPHAN = 2'b10
  } nbload_state_e;

  typedef struct packed {
    nbload_state_e   state;
    logic [RD_W-1:0] rd;
  } nbload_entry_t;

  localparam nbload_entry_t ENTRY_RESET = '{state: FREE, rd: '0};

endpackage

// File: rtl/nbload_cam_ffs.sv
// Find-first-set: lowest-index asserted request bit.
module nbload_ffs #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]         req,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] index
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (req[i-1]) begin
        found = 1'b1;
        index = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/nbload_cam.sv
// Tracks outstanding non-blocking loads and decides whether returning data
// still has the right to be written to the register file.
module nbload_cam
  import nbload_cam_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NLOOKUP = 4,
  parameter int unsigned TAG_W   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   alloc_valid,
  input  logic [4:0]             alloc_rd,
  output logic                   alloc_ready,
  output logic [TAG_W-1:0]       alloc_tag,
  input  logic                   wb_valid,
  input  logic [TAG_W-1:0]       wb_tag,
  output logic                   wb_rd_valid,
  output logic [4:0]             wb_rd,
  output logic                   wb_unexp,
  input  logic                   flush,
  input  logic [NLOOKUP*5-1:0]   lookup_rs,
  output logic [NLOOKUP-1:0]     lookup_hit,
  output logic [TAG_W:0]         count,
  output logic                   empty
);

  localparam int unsigned CNT_W = TAG_W + 1;

  nbload_entry_t    entry_q [DEPTH];
  nbload_entry_t    entry_d [DEPTH];
  logic             wb_rd_valid_q, wb_rd_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_unexp_q, wb_unexp_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] free_vec;
  logic             ffs_found;
  logic [TAG_W-1:0] ffs_index;
  logic             alloc_fire;
  logic             wb_live;
  nbload_entry_t    wb_ent;

  // Free-slot vector from current state only.
  always_comb begin
    free_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      free_vec[i] = (entry_q[i].state == FREE);
    end
  end

  nbload_ffs #(
    .DEPTH (DEPTH)
  ) u_ffs (
    .req   (free_vec),
    .found (ffs_found),
    .index (ffs_index)
  );

  assign alloc_ready = ffs_found;
  assign alloc_tag   = ffs_index;
  assign alloc_fire  = alloc_valid && ffs_found;

  // Source-register lookup against PEND entries of the pre-edge state.
  always_comb begin
    lookup_hit = '0;
    for (int unsigned k = 0; k < NLOOKUP; k++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (entry_q[i].state == PEND && lookup_rs[5*k +: 5] != '0 &&
            entry_q[i].rd == lookup_rs[5*k +: 5]) begin
          lookup_hit[k] = 1'b1;
        end
      end
    end
  end

  // Next-state: orphaning, write-back release, allocation, and counter.
  // Flush or a same-cycle WAW alloc strips write rights from the returning
  // entry before its release is decided, so the release never writes then.
  always_comb begin
    entry_d       = entry_q;
    wb_rd_valid_d = 1'b0;
    wb_rd_d       = '0;
    wb_unexp_d    = 1'b0;
    wb_ent        = ENTRY_RESET;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (TAG_W'(i) == wb_tag) begin
        wb_ent = entry_q[i];
      end
    end
    wb_live    = wb_valid && (wb_ent.state != FREE);
    wb_unexp_d = wb_valid && !wb_live;
    if (wb_live && wb_ent.state == PEND && !flush &&
        !(alloc_fire && alloc_rd == wb_ent.rd)) begin
      wb_rd_valid_d = 1'b1;
      wb_rd_d       = wb_ent.rd;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_q[i].state == PEND &&
          (flush || (alloc_fire && entry_q[i].rd == alloc_rd))) begin
        entry_d[i].state = ORPHAN;
      end
      if (wb_live && TAG_W'(i) == wb_tag) begin
        entry_d[i] = ENTRY_RESET;
      end
      if (alloc_fire && TAG_W'(i) == ffs_index) begin
        entry_d[i].state = (alloc_rd != '0) ? PEND : ORPHAN;
        entry_d[i].rd    = alloc_rd;
      end
    end
    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(wb_live);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= ENTRY_RESET;
      end
      wb_rd_valid_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_unexp_q    <= 1'b0;
      count_q       <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      wb_rd_valid_q <= wb_rd_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_unexp_q    <= wb_unexp_d;
      count_q       <= count_d;
    end
  end

  assign wb_rd_valid = wb_rd_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_unexp    = wb_unexp_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);

endmodule

// File: doc/nbload_cam.md
NBLOAD_CAM -- requirements
Module: nbload_cam

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of outstanding non-blocking load entries (legal values 2..16).
REQ-002 The block SHALL have parameter NLOOKUP, default 4, meaning the number of parallel source-register lookup ports.
REQ-003 The block SHALL have derived parameter TAG_W = $clog2(DEPTH), meaning the tag width.
REQ-004 The block SHALL have the following ports, one per line as name  direction  width  meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_l  in  1  reset; synchronous, active-low.
- alloc_valid  in  1  issue of one non-blocking load.
- alloc_rd  in  5  destination register of the issued load.
- alloc_ready  out  1  at least one FREE entry exists.
- alloc_tag  out  TAG_W  tag that will be assigned if alloc_valid is high this cycle.
- wb_valid  in  1  load data return.
- wb_tag  in  TAG_W  tag of the returning load.
- wb_rd_valid  out  1  registered; write-back to the register file is required.
- wb_rd  out  5  registered destination register for that write-back.
- wb_unexp  out  1  registered one-cycle pulse; wb_tag addressed a FREE entry.
- flush  in  1  pipeline flush; all outstanding loads lose write-back rights.
- lookup_rs  in  NLOOKUP*5  source registers to check; port k uses bits [5k+4:5k].
- lookup_hit  out  NLOOKUP  combinational; a PEND entry matches the source register.
- count  out  TAG_W+1  number of non-FREE entries.
- empty  out  1  count==0.

Function
REQ-005 Each entry SHALL hold state (FREE, PEND, ORPHAN) and a 5-bit rd.
- PEND: write-back is required.
- ORPHAN: data is still outstanding but must not be written.
REQ-006 Entry transitions:
- FREE->PEND on alloc with rd!=0.
- FREE->ORPHAN on alloc with rd==0.
- PEND->ORPHAN on flush, or on a younger alloc with the same rd (WAW).
- PEND or ORPHAN->FREE on wb to its tag.
REQ-007 alloc_ready SHALL equal "any entry FREE" from the current state only; a same-cycle write-back does not make an entry available.
REQ-008 alloc_tag SHALL be the lowest-index FREE entry; alloc_valid with alloc_ready=0 SHALL be ignored, with no state change.
REQ-009 A write-back to a PEND entry SHALL produce wb_rd_valid=1 and wb_rd=entry rd on the next cycle, exactly one cycle wide.
REQ-010 A write-back to an ORPHAN entry SHALL free the entry with wb_rd_valid=0 on the next cycle.
REQ-011 A write-back to a FREE entry SHALL change no state and SHALL pulse wb_unexp on the next cycle.
REQ-012 lookup_hit[k] SHALL be 1 if and only if some PEND entry has rd==lookup_rs[k] and lookup_rs[k]!=0, evaluated on pre-edge state; a same-cycle write-back still hits.
REQ-013 When flush and alloc occur in the same cycle, the new entry SHALL become PEND (or ORPHAN if rd==0) and all older entries SHALL become ORPHAN.
REQ-014 When flush and wb occur in the same cycle, the wb entry SHALL be freed with wb_rd_valid=0, because flush takes priority over write-back rights.
REQ-015 When alloc and wb occur in the same cycle and the wb entry's rd equals alloc_rd, the entry SHALL be freed with wb_rd_valid=0.
REQ-016 count SHALL update on the cycle after alloc/wb, with increment and decrement applied together; it SHALL never exceed DEPTH.

Reset
REQ-017 While rst_l=0 at a clock edge:
- every entry SHALL become FREE with rd=0.
- wb_rd_valid, wb_unexp and wb_rd SHALL be 0.
- count SHALL be 0, empty 1 and alloc_ready 1.
REQ-018 Reset asserted mid-operation SHALL discard all outstanding entries, and write-backs that arrive after reset SHALL report wb_unexp.

Structure
REQ-019 The shared types package SHALL hold:
- enum nbload_state_e (FREE=2'b00, PEND=2'b01, ORPHAN=2'b10).
- struct nbload_entry_t {state, rd[4:0]}.
REQ-020 Find-first-free allocation SHALL be a sub-module nbload_ffs, parametrised by DEPTH, outputting found and index.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, alloc rd=5 -> tag 0, count=1, lookup rs=5 hit; wb tag 0 -> next cycle wb_rd_valid=1, wb_rd=5, count=0, empty=1.
- Fill DEPTH=4 (rd 1..4) -> alloc_ready=0; 5th alloc ignored, count stays 4; wb tag 2 plus alloc in same cycle -> alloc ignored, next alloc_tag=2.
- Alloc rd=7 tag0, alloc rd=7 tag1 -> wb tag0 gives wb_rd_valid=0, lookup rs=7 still hits; wb tag1 gives wb_rd=7.
- Alloc rd=3, rd=9, then flush with alloc rd=12 -> lookups 3/9 miss, 12 hits; wb of all three -> only rd=12 written.
- wb to FREE tag 1 -> wb_unexp pulse one cycle, count unchanged; alloc rd=0 -> no hit, wb gives wb_rd_valid=0.
- Reset with 3 entries outstanding -> count=0; a following wb to tag 0 -> wb_unexp=1.
